// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel synchronizer chain followed by a
// debounce counter, producing a clean registered level plus single-cycle
// rise/fall pulses and a shared busy flag. All outputs come straight from flops.
module input_conditioner #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,    // must be >= 2
    parameter int unsigned DEBOUNCE_CYCLES = 1000  // must be >= 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] i_raw_in,
    output logic [N_CH-1:0] o_clean_out,
    output logic [N_CH-1:0] o_rise_pulse,
    output logic [N_CH-1:0] o_fall_pulse,
    output logic            o_busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which a still-mismatching level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer stages; index SYNC_STAGES-1 is the metastability-free output.
    logic [N_CH-1:0]  r_sync [SYNC_STAGES];
    logic [N_CH-1:0]  w_sync;

    logic [CNT_W-1:0] r_cnt   [N_CH];
    logic [CNT_W-1:0] w_cnt_d [N_CH];

    logic [N_CH-1:0]  r_clean;
    logic [N_CH-1:0]  r_rise;
    logic [N_CH-1:0]  r_fall;
    logic             r_busy;

    logic [N_CH-1:0]  w_clean_d;
    logic [N_CH-1:0]  w_rise_d;
    logic [N_CH-1:0]  w_fall_d;
    logic             w_busy_d;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Shift every raw input through its synchronizer chain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= i_raw_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Per-channel debounce decision: idle, keep counting, or accept the new level.
    always_comb begin
        w_clean_d = r_clean;
        w_rise_d  = '0;
        w_fall_d  = '0;
        w_busy_d  = 1'b0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            w_cnt_d[ch] = '0;
            if (w_sync[ch] != r_clean[ch]) begin
                if (r_cnt[ch] == CNT_LAST) begin
                    w_clean_d[ch] = w_sync[ch];
                    w_rise_d[ch]  = w_sync[ch];
                    w_fall_d[ch]  = ~w_sync[ch];
                end else begin
                    w_cnt_d[ch] = r_cnt[ch] + CNT_W'(1);
                end
            end
            // A match at any point before acceptance leaves the count at zero,
            // which is what rejects glitches shorter than the debounce window.
            w_busy_d = w_busy_d | (w_cnt_d[ch] != '0);
        end
    end

    // Register counters, clean level, pulses and busy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_busy  <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                r_cnt[ch] <= w_cnt_d[ch];
            end
            r_clean <= w_clean_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
            r_busy  <= w_busy_d;
        end
    end

    assign o_clean_out  = r_clean;
    assign o_rise_pulse = r_rise;
    assign o_fall_pulse = r_fall;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (4 channels, 2 sync stages,
// debounce of 4). A history-window reference model is checked every cycle,
// plus directed timing checks and a randomized phase.
module tb_input_conditioner;

    localparam int unsigned NC = 4;
    localparam int S = 2;
    localparam int D = 4;
    localparam int H = S + D;

    logic          clk;
    logic          resetn;
    logic [NC-1:0] raw;
    logic [NC-1:0] clean;
    logic [NC-1:0] rise;
    logic [NC-1:0] fall;
    logic          busy;

    int n_cmp;
    int n_fail;

    // Reference model: recent synchronized history, newest at index 0.
    logic [NC-1:0] m_hist [H];
    logic [NC-1:0] m_clean;
    logic [NC-1:0] m_rise;
    logic [NC-1:0] m_fall;
    logic          m_busy;

    input_conditioner #(
        .N_CH           (NC),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_raw_in    (raw),
        .o_clean_out (clean),
        .o_rise_pulse(rise),
        .o_fall_pulse(fall),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last D values seen after synchronization
    // all disagree with the current clean level.
    task automatic model_update();
        logic all_diff;
        if (!resetn) begin
            for (int i = 0; i < H; i++) m_hist[i] = '0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_busy  = 1'b0;
        end else begin
            for (int i = H - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = raw;
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < int'(NC); ch++) begin
                all_diff = 1'b1;
                for (int k = S; k < H; k++) begin
                    if (m_hist[k][ch] == m_clean[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_clean[ch] = m_hist[S][ch];
                    m_rise[ch]  = m_hist[S][ch];
                    m_fall[ch]  = ~m_hist[S][ch];
                end
            end
            m_busy = |(m_hist[S] ^ m_clean);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_clean", 32'(clean), 32'(m_clean));
        chk("model_rise",  32'(rise),  32'(m_rise));
        chk("model_fall",  32'(fall),  32'(m_fall));
        chk("model_busy",  32'(busy),  32'(m_busy));
    endtask

    initial begin
        int n_r;
        int n_f;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < H; i++) m_hist[i] = '0;
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_busy  = 1'b0;

        // Reset with raw inputs held high; release counts as a 0->1 transition.
        raw    = 4'hF;
        resetn = 1'b0;
        repeat (3) begin
            step();
            chk("reset_outputs", {clean, rise, fall, busy}, 32'h0);
        end
        resetn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) begin
                chk("rel_rise_e6", 32'(rise), 32'hF);
                chk("rel_clean_e6", 32'(clean), 32'hF);
            end else begin
                chk("rel_rise_off", 32'(rise), 32'h0);
            end
            if (e < 6) chk("rel_clean_pre", 32'(clean), 32'h0);
        end

        // Clean rise on channel 0 from a quiet reset.
        raw    = 4'h0;
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        raw    = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("rise0_busy", 32'(busy), (e >= 3 && e <= 5) ? 32'h1 : 32'h0);
            if (e == 6) begin
                chk("rise0_clean_e6", 32'(clean[0]), 32'h1);
                chk("rise0_pulse_e6", 32'(rise[0]), 32'h1);
            end
            if (e == 7) chk("rise0_pulse_e7", 32'(rise[0]), 32'h0);
        end

        // Glitch on channel 1 shorter than the debounce window.
        for (int e = 1; e <= 12; e++) begin
            raw = (e <= 3) ? 4'b0011 : 4'b0001;
            step();
            chk("glitch_clean1", 32'(clean[1]), 32'h0);
            chk("glitch_pulses1", 32'({rise[1], fall[1]}), 32'h0);
        end
        chk("glitch_busy_end", 32'(busy), 32'h0);

        // Bounce on channel 2: toggle every 2 cycles, final rise at e=9.
        n_r = 0;
        n_f = 0;
        for (int e = 1; e <= 22; e++) begin
            raw = 4'b0001;
            if (e >= 9 || (((e - 1) / 2) % 2) == 0) raw[2] = 1'b1;
            step();
            n_r += int'(rise[2]);
            n_f += int'(fall[2]);
            if (e == 14) chk("bounce_rise_e14", 32'(rise[2]), 32'h1);
        end
        chk("bounce_rise_count", 32'(n_r), 32'h1);
        chk("bounce_fall_count", 32'(n_f), 32'h0);

        // Simultaneous fall on all channels.
        raw = 4'hF;
        repeat (8) step();
        chk("all_high", 32'(clean), 32'hF);
        raw = 4'h0;
        n_f = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (fall != 4'h0) n_f++;
            if (e == 6) begin
                chk("simfall_pulse", 32'(fall), 32'hF);
                chk("simfall_clean", 32'(clean), 32'h0);
            end
        end
        chk("simfall_cycles", 32'(n_f), 32'h1);

        // Reset while channel 3 is mid-count.
        raw = 4'b1000;
        repeat (4) step();
        chk("midcnt_busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_clean", 32'(clean), 32'h0);
        resetn = 1'b1;
        n_r = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_r += int'(rise[3]);
            if (e == 6) chk("midrst_rise_e6", 32'(rise[3]), 32'h1);
        end
        chk("midrst_rise_count", 32'(n_r), 32'h1);

        // Randomized toggling with occasional resets.
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < int'(NC); ch++) begin
                if ($urandom_range(5, 0) == 0) raw[ch] = ~raw[ch];
            end
            resetn = ($urandom_range(99, 0) != 0);
            step();
        end
        resetn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
